// File: rtl/bridge_sram_axi_mp_pkg.sv
// +----------------------------------------------------------------------------+
// | bridge_pkg : shared constants, write FSM encoding and width helper for the |
// |              multi-port SRAM-like to AXI3 bridge.                          |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

package bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_LEN_SINGLE = 4'd0;

  typedef enum logic [4:0] {
    W_IDLE      = 5'b00001,
    W_ADDR_DATA = 5'b00010,
    W_ADDR_ONLY = 5'b00100,
    W_DATA_ONLY = 5'b01000,
    W_RESP      = 5'b10000
  } wr_state_t;

  // Smallest r with 2**r >= value.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bridge_sram_axi_mp_prio_arb.sv
// +----------------------------------------------------------------------------+
// | bridge_prio_arb : fixed-priority one-hot arbiter, highest index wins.      |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module bridge_prio_arb #(
  parameter int NUM_PORTS = 2
) (
  input  logic [NUM_PORTS-1:0] request,
  output logic [NUM_PORTS-1:0] grant
);

  always_comb begin
    logic taken;
    taken = 1'b0;
    grant = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (request[i] && !taken) begin
        grant[i] = 1'b1;
        taken    = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bridge_sram_axi_mp.sv
// +----------------------------------------------------------------------------+
// | bridge_sram_axi_mp : NUM_PORTS SRAM-like requesters onto one AXI3 master,  |
// |   up to OUTSTANDING reads per port routed by ID, one write at a time.      |
// |   Optional macro BRIDGE_RAW_CHECK_EN enables the read-after-write check.   |
// | Revision           : 1.0                                                   |
// +----------------------------------------------------------------------------+
`default_nettype none

module bridge_sram_axi_mp
  import bridge_pkg::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int OUTSTANDING = 2,
  parameter int ID_W        = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  // SRAM-like requesters
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    wr,
  input  logic [2*NUM_PORTS-1:0]  size,
  input  logic [32*NUM_PORTS-1:0] addr,
  input  logic [32*NUM_PORTS-1:0] req_wdata,
  input  logic [4*NUM_PORTS-1:0]  req_wstrb,
  output logic [NUM_PORTS-1:0]    addr_ok,
  output logic [NUM_PORTS-1:0]    data_ok,
  output logic [32*NUM_PORTS-1:0] resp_rdata,
  // AR
  output logic [ID_W-1:0]         arid,
  output logic [31:0]             araddr,
  output logic [3:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic [1:0]              arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic                    arvalid,
  input  logic                    arready,
  // R
  input  logic [ID_W-1:0]         rid,
  input  logic [31:0]             rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready,
  // AW
  output logic [ID_W-1:0]         awid,
  output logic [31:0]             awaddr,
  output logic [3:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [1:0]              awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic                    awvalid,
  input  logic                    awready,
  // W
  output logic [ID_W-1:0]         wid,
  output logic [31:0]             wdata,
  output logic [3:0]              wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  // B
  input  logic [ID_W-1:0]         bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready
);

  localparam int              CNT_W   = clog2(OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OUTSTANDING);

  wr_state_t            wstate;
  logic [CNT_W-1:0]     rd_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] rd_elig, wr_elig, rd_grant, wr_grant;
  logic [NUM_PORTS-1:0] r_hit, b_hit, wr_owner, raw_block;
  logic                 r_fire, b_fire;
  logic [31:0]          rd_sel_addr, wr_sel_addr, wr_sel_data;
  logic [1:0]           rd_sel_size, wr_sel_size;
  logic [3:0]           wr_sel_strb;
  logic [ID_W-1:0]      rd_sel_id, wr_sel_id;
  logic                 unused_ok;

  assign unused_ok = ^{rresp, rlast, bresp};

  assign arlen   = AXI_LEN_SINGLE;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;
  assign awlen   = AXI_LEN_SINGLE;
  assign awburst = AXI_BURST_INCR;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;
  assign wlast   = 1'b1;
  assign wid     = awid;

  assign r_fire = rvalid & rready;
  assign b_fire = bvalid & bready;

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      wr_owner[p] = (wstate != W_IDLE) && (awid == ID_W'(p));
`ifdef BRIDGE_RAW_CHECK_EN
      raw_block[p] = (wstate != W_IDLE) && (addr[32*p+2 +: 30] == awaddr[31:2]);
`else
      raw_block[p] = 1'b0;
`endif
      rd_elig[p] = aresetn && req[p] && !wr[p] && !arvalid && (rd_cnt[p] < CNT_MAX)
                   && !wr_owner[p] && !raw_block[p];
      wr_elig[p] = aresetn && (wstate == W_IDLE) && req[p] && wr[p] && (rd_cnt[p] == '0);
      r_hit[p]   = r_fire && (rid == ID_W'(p));
      b_hit[p]   = b_fire && (bid == ID_W'(p));
    end
  end

  bridge_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_rd_arb (
    .request (rd_elig),
    .grant   (rd_grant)
  );

  bridge_prio_arb #(.NUM_PORTS(NUM_PORTS)) u_wr_arb (
    .request (wr_elig),
    .grant   (wr_grant)
  );

  assign addr_ok = rd_grant | wr_grant;

  always_comb begin
    rd_sel_addr = '0;
    rd_sel_size = '0;
    rd_sel_id   = '0;
    wr_sel_addr = '0;
    wr_sel_data = '0;
    wr_sel_size = '0;
    wr_sel_strb = '0;
    wr_sel_id   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rd_grant[p]) begin
        rd_sel_addr = addr[32*p +: 32];
        rd_sel_size = size[2*p +: 2];
        rd_sel_id   = ID_W'(p);
      end
      if (wr_grant[p]) begin
        wr_sel_addr = addr[32*p +: 32];
        wr_sel_data = req_wdata[32*p +: 32];
        wr_sel_size = size[2*p +: 2];
        wr_sel_strb = req_wstrb[4*p +: 4];
        wr_sel_id   = ID_W'(p);
      end
    end
  end

  // Single AR slot: a new read is only granted while it is empty.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      arvalid <= 1'b0;
      araddr  <= '0;
      arsize  <= '0;
      arid    <= '0;
      rready  <= 1'b0;
    end else begin
      rready <= 1'b1;
      if (|rd_grant) begin
        arvalid <= 1'b1;
        araddr  <= rd_sel_addr;
        arsize  <= {1'b0, rd_sel_size};
        arid    <= rd_sel_id;
      end else if (arready) begin
        arvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      data_ok    <= '0;
      resp_rdata <= '0;
      for (int p = 0; p < NUM_PORTS; p++) rd_cnt[p] <= '0;
    end else begin
      data_ok <= r_hit | b_hit;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (r_hit[p]) resp_rdata[32*p +: 32] <= rdata;
        // Beats for an idle port are ignored rather than wrapping the count.
        if (rd_grant[p] && !(r_hit[p] && rd_cnt[p] != '0)) begin
          rd_cnt[p] <= rd_cnt[p] + CNT_W'(1);
        end else if (!rd_grant[p] && r_hit[p] && rd_cnt[p] != '0) begin
          rd_cnt[p] <= rd_cnt[p] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wstate  <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
      awaddr  <= '0;
      awsize  <= '0;
      awid    <= '0;
      wdata   <= '0;
      wstrb   <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (|wr_grant) begin
            awaddr  <= wr_sel_addr;
            awsize  <= {1'b0, wr_sel_size};
            awid    <= wr_sel_id;
            wdata   <= wr_sel_data;
            wstrb   <= wr_sel_strb;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            wstate  <= W_ADDR_DATA;
          end
        end
        W_ADDR_DATA: begin
          if (awready) awvalid <= 1'b0;
          if (wready)  wvalid  <= 1'b0;
          if (awready && wready) begin
            bready <= 1'b1;
            wstate <= W_RESP;
          end else if (awready) begin
            wstate <= W_DATA_ONLY;
          end else if (wready) begin
            wstate <= W_ADDR_ONLY;
          end
        end
        W_ADDR_ONLY: begin
          if (awready) begin
            awvalid <= 1'b0;
            bready  <= 1'b1;
            wstate  <= W_RESP;
          end
        end
        W_DATA_ONLY: begin
          if (wready) begin
            wvalid <= 1'b0;
            bready <= 1'b1;
            wstate <= W_RESP;
          end
        end
        W_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            wstate <= W_IDLE;
          end
        end
        default: begin
          awvalid <= 1'b0;
          wvalid  <= 1'b0;
          bready  <= 1'b0;
          wstate  <= W_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bridge_sram_axi_mp.sv
// Directed bench for bridge_sram_axi_mp: transaction-level model checked every
// cycle on the falling edge, plus literal expectations at key cycles.
`default_nettype none

module tb_bridge_sram_axi_mp;

  localparam int NP  = 2;
  localparam int OUT = 2;
  localparam int IDW = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [NP-1:0]   req, wr;
  logic [2*NP-1:0] size;
  logic [32*NP-1:0] addr, req_wdata;
  logic [4*NP-1:0] req_wstrb;
  logic [NP-1:0]   addr_ok, data_ok;
  logic [32*NP-1:0] resp_rdata;
  logic [IDW-1:0]  arid, rid, awid, wid, bid;
  logic [31:0]     araddr, rdata, awaddr, wdata;
  logic [3:0]      arlen, arcache, awlen, awcache, wstrb;
  logic [2:0]      arsize, arprot, awsize, awprot;
  logic [1:0]      arburst, arlock, rresp, awburst, awlock, bresp;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  bridge_sram_axi_mp #(.NUM_PORTS(NP), .OUTSTANDING(OUT), .ID_W(IDW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req(req), .wr(wr), .size(size), .addr(addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .addr_ok(addr_ok), .data_ok(data_ok), .resp_rdata(resp_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  bit          m_valid = 1'b0;
  int          m_cnt [NP];
  bit          m_ar_busy, m_wbusy, m_aw_pend, m_w_pend, m_bready, m_rready;
  logic [31:0] m_ar_addr, m_waddr, m_wdata;
  logic [2:0]  m_ar_size, m_wsize;
  logic [3:0]  m_wstrb;
  int          m_ar_id, m_wport;
  logic [NP-1:0] m_data_ok;
  logic [31:0] m_rdata [NP];

  function automatic logic [NP-1:0] exp_addr_ok();
    logic [NP-1:0] res;
    bit rd_done, wr_done;
    res = '0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    if (!aresetn) return '0;
    for (int p = NP - 1; p >= 0; p--) begin
      logic [31:0] a;
      bit raw;
      a = addr[32*p +: 32];
      raw = 1'b0;
`ifdef BRIDGE_RAW_CHECK_EN
      raw = m_wbusy && (a[31:2] == m_waddr[31:2]);
`endif
      if (!rd_done && req[p] && !wr[p] && !m_ar_busy && m_cnt[p] < OUT
          && !(m_wbusy && m_wport == p) && !raw) begin
        res[p]  = 1'b1;
        rd_done = 1'b1;
      end
      if (!wr_done && req[p] && wr[p] && !m_wbusy && m_cnt[p] == 0) begin
        res[p]  = 1'b1;
        wr_done = 1'b1;
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < NP; p++) begin
      m_cnt[p]   = 0;
      m_rdata[p] = '0;
    end
    m_ar_busy = 0; m_wbusy = 0; m_aw_pend = 0; m_w_pend = 0;
    m_bready = 0; m_rready = 0; m_data_ok = '0;
  endtask

  task automatic compare_cycle();
    logic [NP-1:0] eo;
    eo = exp_addr_ok();
    check("addr_ok", addr_ok, eo);
    check("data_ok", data_ok, m_data_ok);
    for (int p = 0; p < NP; p++)
      check($sformatf("rdata[%0d]", p), resp_rdata[32*p +: 32], m_rdata[p]);
    check("rready", rready, m_rready);
    check("arvalid", arvalid, m_ar_busy);
    if (m_ar_busy) begin
      check("araddr", araddr, m_ar_addr);
      check("arid", arid, m_ar_id);
      check("arsize", arsize, m_ar_size);
    end
    check("awvalid", awvalid, m_aw_pend);
    check("wvalid", wvalid, m_w_pend);
    check("bready", bready, m_bready);
    if (m_aw_pend) begin
      check("awaddr", awaddr, m_waddr);
      check("awid", awid, m_wport);
      check("awsize", awsize, m_wsize);
    end
    if (m_w_pend) begin
      check("wdata", wdata, m_wdata);
      check("wstrb", wstrb, m_wstrb);
      check("wid", wid, m_wport);
    end
    check("ar_consts", {arlen, arburst, arlock, arcache, arprot}, {4'd0, 2'b01, 2'd0, 4'd0, 3'd0});
    check("aw_consts", {awlen, awburst, awlock, awcache, awprot, wlast},
          {4'd0, 2'b01, 2'd0, 4'd0, 3'd0, 1'b1});
  endtask

  task automatic model_step();
    logic [NP-1:0] acc;
    bit r_hs, b_hs;
    int ri, bi;
    if (!aresetn) begin
      model_reset();
      m_valid = 1'b1;
      return;
    end
    acc  = exp_addr_ok();
    r_hs = rvalid && m_rready;
    b_hs = bvalid && m_bready;
    ri   = int'(rid);
    bi   = int'(bid);
    m_data_ok = '0;
    if (r_hs && ri < NP) begin
      m_data_ok[ri] = 1'b1;
      m_rdata[ri]   = rdata;
      if (m_cnt[ri] > 0) m_cnt[ri]--;
    end
    if (b_hs && bi < NP) m_data_ok[bi] = 1'b1;
    if (b_hs) m_wbusy = 1'b0;
    if (m_ar_busy && arready) m_ar_busy = 1'b0;
    if (m_aw_pend && awready) m_aw_pend = 1'b0;
    if (m_w_pend && wready) m_w_pend = 1'b0;
    for (int p = 0; p < NP; p++) begin
      if (acc[p] && !wr[p]) begin
        m_cnt[p]++;
        m_ar_busy = 1'b1;
        m_ar_addr = addr[32*p +: 32];
        m_ar_size = {1'b0, size[2*p +: 2]};
        m_ar_id   = p;
      end
      if (acc[p] && wr[p]) begin
        m_wbusy = 1'b1; m_aw_pend = 1'b1; m_w_pend = 1'b1;
        m_wport = p;
        m_waddr = addr[32*p +: 32];
        m_wdata = req_wdata[32*p +: 32];
        m_wstrb = req_wstrb[4*p +: 4];
        m_wsize = {1'b0, size[2*p +: 2]};
      end
    end
    m_bready = m_wbusy && !m_aw_pend && !m_w_pend;
    m_rready = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge aclk);
      if (m_valid) compare_cycle();
      model_step();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic r_beat(input logic [IDW-1:0] id, input logic [31:0] d);
    rvalid = 1'b1; rid = id; rdata = d;
    step();
    rvalid = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0;
    req = '0; wr = '0; size = '0; addr = '0; req_wdata = '0; req_wstrb = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    check("rst_rready", rready, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_arburst", arburst, 2'b01);
    check("rst_wlast", wlast, 1'b1);
    check("rst_data_ok", data_ok, 2'b00);
    aresetn = 1'b1;
    step();
    check("rready_up", rready, 1'b1);

    // Both ports read together; port 1 wins, port 0 gets the next free slot.
    arready = 1'b1;
    req = 2'b11; wr = 2'b00; size = 4'b1010;
    addr = {32'h0000_0200, 32'h0000_0100};
    #1 check("prio_grant", addr_ok, 2'b10);
    step(); req[1] = 1'b0;
    #1 check("prio_arid", arid, 4'd1);
    check("prio_araddr", araddr, 32'h0000_0200);
    check("prio_slot_busy", addr_ok, 2'b00);
    step();
    #1 check("p0_next_slot", addr_ok, 2'b01);
    step(); req = '0;
    #1 check("p0_araddr", araddr, 32'h0000_0100);
    check("p0_arid", arid, 4'd0);
    step();

    // Interleaved responses.
    rvalid = 1'b1; rid = 4'd1; rdata = 32'hAAAA_0001;
    step(); rid = 4'd0; rdata = 32'h5555_0000;
    #1 check("ilv_ok1", data_ok, 2'b10);
    check("ilv_rdata1", resp_rdata[63:32], 32'hAAAA_0001);
    step(); rvalid = 1'b0;
    #1 check("ilv_ok0", data_ok, 2'b01);
    check("ilv_rdata0", resp_rdata[31:0], 32'h5555_0000);
    check("ilv_rdata1_hold", resp_rdata[63:32], 32'hAAAA_0001);
    step();

    // Outstanding limit on port 0.
    req[0] = 1'b1; addr[31:0] = 32'h0000_0300;
    #1 check("lim_acc1", addr_ok, 2'b01);
    step(); addr[31:0] = 32'h0000_0304;
    #1 check("lim_slot1", addr_ok, 2'b00);
    step();
    #1 check("lim_acc2", addr_ok, 2'b01);
    step(); addr[31:0] = 32'h0000_0308;
    #1 check("lim_slot2", addr_ok, 2'b00);
    step();
    #1 check("lim_full", addr_ok, 2'b00);
    step();
    #1 check("lim_full2", addr_ok, 2'b00);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h1111_0000;
    step(); rvalid = 1'b0;
    #1 check("lim_data_ok", data_ok, 2'b01);
    check("lim_acc3", addr_ok, 2'b01);
    step(); req = '0;
    step();
    r_beat(4'd0, 32'h2222_0000);
    r_beat(4'd0, 32'h3333_0000);
    step();

    // Write with awready delayed and wready immediate.
    awready = 1'b0; wready = 1'b1;
    req[1] = 1'b1; wr[1] = 1'b1; addr[63:32] = 32'h0000_1000;
    req_wdata[63:32] = 32'hDEAD_BEEF; req_wstrb[7:4] = 4'hF; size[3:2] = 2'd2;
    #1 check("wr_accept", addr_ok, 2'b10);
    step(); req = '0; wr = '0;
    #1 check("wr_valids", {awvalid, wvalid, bready}, 3'b110);
    step();
    #1 check("wr_addr_only", {awvalid, wvalid, bready}, 3'b100);
    step();
    #1 check("wr_wait_b", bready, 1'b0);
    step(); awready = 1'b1;
    #1 check("wr_wait_b2", bready, 1'b0);
    step(); awready = 1'b0; wready = 1'b0;
    #1 check("wr_resp", {awvalid, bready}, 2'b01);
    bvalid = 1'b1; bid = 4'd1;
    step(); bvalid = 1'b0;
    #1 check("wr_data_ok", data_ok, 2'b10);
    check("wr_bready_drop", bready, 1'b0);
    step();

    // Read while a write to 0x1004 is pending.
    req[1] = 1'b1; wr[1] = 1'b1; addr[63:32] = 32'h0000_1004;
    req_wdata[63:32] = 32'h1234_5678; req_wstrb[7:4] = 4'h3; size[3:2] = 2'd1;
    #1 check("raw_wr_accept", addr_ok, 2'b10);
    step(); req[1] = 1'b0; wr[1] = 1'b0;
    req[0] = 1'b1; addr[31:0] = 32'h0000_1008;
    #1 check("raw_other_addr", addr_ok, 2'b01);
    step(); addr[31:0] = 32'h0000_1004;
    #1 check("raw_slot", addr_ok, 2'b00);
    step();
`ifdef BRIDGE_RAW_CHECK_EN
    #1 check("raw_block", addr_ok, 2'b00);
    step();
    #1 check("raw_block2", addr_ok, 2'b00);
    awready = 1'b1; wready = 1'b1;
    step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
    #1 check("raw_bready", bready, 1'b1);
    check("raw_block3", addr_ok, 2'b00);
    step(); bvalid = 1'b0;
    #1 check("raw_wr_done", data_ok, 2'b10);
    check("raw_release", addr_ok, 2'b01);
    step(); req = '0;
`else
    #1 check("no_raw_block", addr_ok, 2'b01);
    step(); req = '0; awready = 1'b1; wready = 1'b1;
    step(); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd1;
    #1 check("raw_bready", bready, 1'b1);
    step(); bvalid = 1'b0;
    #1 check("raw_wr_done", data_ok, 2'b10);
    step();
`endif
    step();
    r_beat(4'd0, 32'h4444_0000);
    r_beat(4'd0, 32'h6666_0000);
    step();

    // Reset while a read sits in the AR slot.
    arready = 1'b0;
    req[0] = 1'b1; addr[31:0] = 32'h0000_2000; size[1:0] = 2'd2;
    #1 check("mid_rd_accept", addr_ok, 2'b01);
    step(); req = '0;
    #1 check("mid_rd_arvalid", arvalid, 1'b1);
    aresetn = 1'b0;
    step(); aresetn = 1'b1;
    #1 check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_data_ok", data_ok, 2'b00);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_araddr", araddr, 32'h0);
    check("mid_rst_wr", {awvalid, wvalid, bready}, 3'b000);
    check("mid_rst_rdata", resp_rdata, 64'h0);
    step();
    #1 check("mid_rst_rready_up", rready, 1'b1);

    // Counter cleared: two fresh reads from port 0 must both be accepted.
    arready = 1'b1;
    req[0] = 1'b1; addr[31:0] = 32'h0000_3000;
    #1 check("post_rst_acc1", addr_ok, 2'b01);
    step(); addr[31:0] = 32'h0000_3004;
    step();
    #1 check("post_rst_acc2", addr_ok, 2'b01);
    step(); req = '0;
    step();
    r_beat(4'd0, 32'h7777_0000);
    r_beat(4'd0, 32'h8888_0000);
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bridge_sram_axi_mp.md
# bridge_sram_axi_mp

Parametrised multi-port SRAM-like-to-AXI3 bridge sitting between the CPU core's instruction/data SRAM-like ports and the single AXI master interface to the crossbar. It generalises the two-port single-outstanding bridge to NUM_PORTS requesters and up to OUTSTANDING in-flight reads per port, using the AXI ID to route responses. Writes remain one-at-a-time with an optional read-after-write address hazard check.

## Interface
- NUM_PORTS, 2: SRAM-like requesters. Port index is the AXI ID; highest index has highest priority.
- OUTSTANDING, 2: maximum accepted-but-unanswered reads per port (≥1).
- ID_W, 4: AXI ID width. Must satisfy 2^ID_W ≥ NUM_PORTS.
- aclk in 1: clock.
- aresetn in 1: reset, synchronous, active-low.
- req, wr in NUM_PORTS: per-port request and write flag.
- size in 2*NUM_PORTS: per-port byte count, log2 encoded.
- addr, wdata in 32*NUM_PORTS: per-port address and write data.
- wstrb in 4*NUM_PORTS: per-port byte enables.
- addr_ok, data_ok out NUM_PORTS: per-port accept pulse and completion pulse.
- rdata out 32*NUM_PORTS: per-port registered read data.
- AXI3 master channels:
  - AR: arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid out, arready in.
  - R: rid/rdata/rresp/rlast/rvalid in, rready out.
  - AW: awid…awprot/awvalid out, awready in.
  - W: wid/wdata/wstrb/wlast/wvalid out, wready in.
  - B: bid/bresp/bvalid in, bready out.
  - Widths are as in AXI3 with ID_W ids.

## Operation
- Constant fields: arlen/awlen = 0, arburst/awburst = 2'b01, lock/cache/prot = 0, wlast = 1. rresp/bresp/rlast are ignored.
- **Read accept** of port p requires all of:
  - req[p] & ~wr[p];
  - AR slot empty (arvalid = 0);
  - rd_cnt[p] < OUTSTANDING;
  - no write from p outstanding;
  - no RAW hazard (see Configuration);
  - p is the highest eligible index.
- **On read accept:**
  - addr_ok[p] = 1 in the same cycle (combinational).
  - araddr, arsize = {1'b0, size}, and arid = p are registered.
  - arvalid rises the next cycle and holds until arready.
- **rd_cnt[p]** (width clog2(OUTSTANDING+1)):
  - +1 on accept, −1 on an R handshake with rid = p.
  - Both in one cycle: the count holds.
- **rready** is 0 in reset and 1 from the first cycle after reset.
- **R handshake:** rdata[rid] <= rdata, and data_ok[rid] pulses the next cycle. Other ports' rdata hold.
- Interleaved rids are legal. Per-ID order is preserved by AXI.
- **Write engine FSM:** W_IDLE → W_ADDR_DATA → (W_ADDR_ONLY | W_DATA_ONLY) → W_RESP → W_IDLE.
- **Write accept** from W_IDLE requires req[p] & wr[p], rd_cnt[p] == 0, and p being the highest eligible index.
  - addr_ok[p] = 1 in the same cycle.
  - awaddr/awsize/wdata/wstrb are registered, and awid = wid = p.
- **Write channel handshakes:**
  - awvalid and wvalid both rise the next cycle.
  - Each drops independently after its own handshake. If both complete in one cycle, the FSM goes directly to W_RESP.
- **Write response:** bready = 1 only in W_RESP. The B handshake returns the FSM to W_IDLE, and data_ok[bid] pulses the next cycle.
- A read accept and a write accept to different ports may occur in the same cycle.
- **Reset mid-operation:** all FSMs, counters and slots clear, and in-flight transactions are abandoned.
- **Reset values:**
  - All valid/ready, addr_ok and data_ok outputs = 0.
  - rdata, addresses, ids, wdata and wstrb = 0; sizes = 0.
  - arburst/awburst = 2'b01, wlast = 1.

## Timing
- Read: addr_ok at T, arvalid at T+1. With arready = 1 and the R handshake at cycle R, data_ok and rdata are valid at R+1. Minimum latency is T+3 with a zero-wait slave.
- Back-to-back reads: the next read is accepted at T+2 at the earliest, because the AR slot must be empty.
- Write: addr_ok at T, aw/wvalid at T+1, B handshake at B, data_ok at B+1.
- data_ok is a single-cycle pulse. Masters must capture it; there is no back-pressure.

## Configuration
- **BRIDGE_RAW_CHECK_EN defined:** a read is blocked while the write FSM is not in W_IDLE and addr[31:2] matches awaddr[31:2].
- **BRIDGE_RAW_CHECK_EN undefined:** there is no address comparison. Reads issue regardless of pending writes, and software/slave ordering is relied upon.

## Structure
- Package bridge_pkg holds:
  - AXI_BURST_INCR, AXI_LEN_SINGLE;
  - write FSM state encoding (one-hot);
  - the clog2 helper for counter widths.
- Sub-module bridge_prio_arb: NUM_PORTS-wide fixed-priority (highest index) one-hot grant. It is instantiated twice, once for reads and once for writes.

## Test plan
- **Port 1 and port 0 both read at T:** grant port 1. arid = 1 and araddr = port 1 address at T+1; port 0 is accepted at T+2 (next free slot).
- **Port 0 issues 3 reads with OUTSTANDING = 2 and no R beats:** third addr_ok stays 0. R with rid = 0 → data_ok[0] at the next cycle, and the third read is accepted one cycle after the counter drops.
- **Interleaved R beats:** rid = 1 with data 0xAAAA_0001, then rid = 0 with data 0x5555_0000. rdata[1] = 0xAAAA_0001 with data_ok[1], then rdata[0] = 0x5555_0000 with data_ok[0], on consecutive cycles.
- **Write addr 0x1000 with awready delayed 3 cycles and wready immediate:** FSM passes through W_ADDR_ONLY. bready is asserted only after both handshakes; data_ok[1] at B+1.
- **BRIDGE_RAW_CHECK_EN, write 0x1004 pending, port 0 read 0x1004:** addr_ok[0] is held 0 until one cycle after the B handshake. A read to 0x1008 is accepted immediately.
- **aresetn low for 1 cycle mid-read (arvalid = 1):** next cycle arvalid = 0, rd_cnt = 0, data_ok = 0, and all outputs are at reset values.
